// File: rtl/gpio_in_debounce.sv
// Switch input conditioner: per-bit synchroniser, stability-counter debounce, rise/fall strobes, sticky changed flag.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges from raw change to sw_out; no backpressure, changed held until acked.
module gpio_in_debounce #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    input  logic             changed_ack
);
    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]                  sw_q, sw_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic                              changed_q, changed_d;
    logic [WIDTH-1:0]                  upd;
    logic [WIDTH-1:0]                  s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
        cnt_d  = cnt_q;
        sw_d   = sw_q;
        upd    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            // Any return to the current level restarts qualification.
            if (s[i] == sw_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                upd[i]   = 1'b1;
                sw_d[i]  = s[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        rise_d = upd & s;
        fall_d = upd & ~s;
        // A new flip beats a same-cycle acknowledge so no edge is lost.
        if (|upd) begin
            changed_d = 1'b1;
        end else if (changed_ack) begin
            changed_d = 1'b0;
        end else begin
            changed_d = changed_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            sw_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            sw_q      <= sw_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign sw_out  = sw_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce: stimulus queues expected strobe events, a negedge monitor checks them.
module tb_gpio_in_debounce;

    logic       clk;
    logic       reset;
    logic [7:0] raw_in;
    logic [7:0] sw_out;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       changed;
    logic       changed_ack;

    gpio_in_debounce #(
        .WIDTH          (8),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .sw_out     (sw_out),
        .rise       (rise),
        .fall       (fall),
        .changed    (changed),
        .changed_ack(changed_ack)
    );

    typedef struct {
        int         cyc;
        logic [7:0] sw;
        logic [7:0] rs;
        logic [7:0] fl;
    } ev_t;

    ev_t sb[$];
    int  cyc   = 0;
    int  n_vec = 0;
    int  n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected strobe event dly edges after the current point.
    task automatic expect_ev(input int dly, input logic [7:0] sw, input logic [7:0] rs, input logic [7:0] fl);
        ev_t e;
        e.cyc = cyc + dly;
        e.sw  = sw;
        e.rs  = rs;
        e.fl  = fl;
        sb.push_back(e);
    endtask

    task automatic ack_pulse();
        changed_ack = 1'b1;
        step(1);
        changed_ack = 1'b0;
    endtask

    always @(negedge clk) begin
        ev_t e;
        if ((rise | fall) != 8'h00) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {16'h0, rise, fall}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("ev_cycle", cyc, e.cyc);
                chk("ev_sw_out", sw_out, e.sw);
                chk("ev_rise", rise, e.rs);
                chk("ev_fall", fall, e.fl);
                chk("ev_changed", changed, 1);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        raw_in      = 8'h00;
        changed_ack = 1'b0;
        step(3);
        chk("rst_sw_out", sw_out, 8'h00);
        chk("rst_rise", rise, 8'h00);
        chk("rst_fall", fall, 8'h00);
        chk("rst_changed", changed, 0);
        reset = 1'b0;

        // Clean press of bit 0
        raw_in = 8'h01;
        expect_ev(18, 8'h01, 8'h01, 8'h00);
        step(17);
        chk("press_pre_edge_sw", sw_out, 8'h00);
        step(2);
        chk("press_rise_one_cycle", rise, 8'h00);
        chk("press_sw_held", sw_out, 8'h01);
        chk("press_changed_sticky", changed, 1);
        ack_pulse();
        chk("ack_clears", changed, 0);

        // 15-cycle glitch on bit 3 must be rejected
        raw_in = 8'h09;
        step(15);
        raw_in = 8'h01;
        step(25);
        chk("glitch_sw_out", sw_out, 8'h01);
        chk("glitch_changed", changed, 0);

        // Release bit 0, then bounce it and settle high
        raw_in = 8'h00;
        expect_ev(18, 8'h00, 8'h00, 8'h01);
        step(20);
        ack_pulse();
        for (int k = 0; k < 10; k++) begin
            raw_in = (k % 2 == 0) ? 8'h01 : 8'h00;
            step(3);
        end
        chk("bounce_no_early_flip", sw_out, 8'h00);
        raw_in = 8'h01;
        expect_ev(18, 8'h01, 8'h01, 8'h00);
        step(20);
        chk("bounce_settled_sw", sw_out, 8'h01);

        raw_in = 8'h00;
        expect_ev(18, 8'h00, 8'h00, 8'h01);
        step(20);
        ack_pulse();
        chk("pre_multi_changed", changed, 0);

        // Multi-bit press with ack landing on the qualifying edge
        raw_in = 8'hA5;
        expect_ev(18, 8'hA5, 8'hA5, 8'h00);
        step(17);
        chk("multi_pre_edge_sw", sw_out, 8'h00);
        ack_pulse();
        chk("set_beats_ack", changed, 1);
        step(1);
        chk("multi_sw_out", sw_out, 8'hA5);

        raw_in = 8'h00;
        expect_ev(18, 8'h00, 8'h00, 8'hA5);
        step(20);
        chk("release_sw_out", sw_out, 8'h00);

        // Reset in the middle of qualification
        raw_in = 8'hFF;
        step(10);
        reset = 1'b1;
        step(1);
        chk("midrst_changed", changed, 0);
        reset = 1'b0;
        expect_ev(18, 8'hFF, 8'hFF, 8'h00);
        step(17);
        chk("midrst_pre_edge_sw", sw_out, 8'h00);
        step(3);
        chk("midrst_sw_out", sw_out, 8'hFF);

        step(5);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
